// File: rtl/sample_readout.sv
// Trigger-capture readout engine: walks the circular capture RAM from the oldest
// sample to the stop address and streams each sample out over a valid/ready port.
module sample_readout #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              trig_clk,
    input  logic              trig_rstn,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_flag,
    input  logic              overflow_flag,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic [15:0]       trig_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = 17;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARM     = 3'd1;
    localparam logic [2:0] FETCH   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] PRESENT = 3'd4;

    // Circular increment: the buffer is trig_len deep, not 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input logic [15:0]       len);
        logic [CNT_W-1:0] nxt;
        nxt = CNT_W'(a) + 17'd1;
        if (nxt == {1'b0, len}) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = nxt[ADDR_W-1:0];
        end
    endfunction

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [15:0]       len_r;

    logic [2:0]        state_nxt_s;
    logic              load_s;
    logic              adv_s;
    logic              finish_s;
    logic              trig_s;
    logic [CNT_W-1:0]  sp1_s;
    logic [CNT_W-1:0]  count_s;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] addr_adv_s;
    logic              capture_s;

    // Window geometry derived from the trigger node's current flags.
    always_comb begin
        sp1_s      = CNT_W'(stop_addr) + 17'd1;
        addr_adv_s = wrap_inc(addr_r, len_r);
        if (overflow_flag) begin
            count_s = {1'b0, trig_len};
            base_s  = wrap_inc(stop_addr, trig_len);
        end else begin
            count_s = (sp1_s > {1'b0, trig_len}) ? {1'b0, trig_len} : sp1_s;
            base_s  = '0;
        end
    end

    // Next-state logic; abort overrides everything and never pulses done.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        adv_s       = 1'b0;
        finish_s    = 1'b0;
        trig_s      = 1'b0;
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && stop_flag) begin
                        trig_s = 1'b1;
                    end else if (start) begin
                        state_nxt_s = ARM;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARM: begin
                    if (stop_flag) begin
                        trig_s = 1'b1;
                    end else begin
                        state_nxt_s = ARM;
                    end
                end
                FETCH:   state_nxt_s = WAIT;
                WAIT:    state_nxt_s = PRESENT;
                PRESENT: begin
                    if (out_ready && (cnt_r == 17'd1)) begin
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (out_ready) begin
                        adv_s       = 1'b1;
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = PRESENT;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
            // An empty window completes immediately without touching the RAM.
            if (trig_s && (count_s == 17'd0)) begin
                finish_s    = 1'b1;
                state_nxt_s = IDLE;
            end else if (trig_s) begin
                load_s      = 1'b1;
                state_nxt_s = FETCH;
            end else begin
                load_s = 1'b0;
            end
        end
        capture_s = (state_r == WAIT) && (state_nxt_s == PRESENT);
    end

    // State, window registers and registered outputs.
    always_ff @(posedge trig_clk or negedge trig_rstn) begin
        if (!trig_rstn) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            cnt_r     <= '0;
            len_r     <= 16'd0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rd_en     <= (state_nxt_s == FETCH);
            busy      <= (state_nxt_s != IDLE);
            done      <= finish_s;
            out_valid <= (state_nxt_s == PRESENT);
            if (load_s) begin
                addr_r  <= base_s;
                cnt_r   <= count_s;
                len_r   <= trig_len;
                rd_addr <= base_s;
            end else if (adv_s) begin
                addr_r  <= addr_adv_s;
                cnt_r   <= cnt_r - 17'd1;
                rd_addr <= addr_adv_s;
            end else begin
                addr_r <= addr_r;
            end
            if (capture_s) begin
                out_data <= rd_data;
                out_last <= (cnt_r == 17'd1);
            end else if (state_nxt_s != PRESENT) begin
                out_last <= 1'b0;
            end else begin
                out_last <= out_last;
            end
        end
    end

endmodule
